// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Prefetching instruction fetch stage. Streams sequential words out of a
// 1-cycle-latency synchronous BRAM into a DEPTH-entry {pc, instr} FIFO and
// hands them to decode with a valid/next handshake. A redirect (c_flush)
// discards everything queued or in flight and restarts fetch at c_target.
//
// Optional feature: define FETCH_QUEUE_BYPASS_EN to let a returning word
// go straight to the head outputs when the FIFO is empty (one cycle less
// flush-to-valid latency). Without the macro every word passes through the
// FIFO.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   o_mem_en       BRAM read enable
//   o_mem_addr     BRAM word address (request pc[ADDR_W-1:2])
//   i_mem_data     BRAM read data, valid the cycle after o_mem_en
//   o_instr, o_pc  head instruction and its PC
//   o_valid        head entry valid
//   i_next         decode consumes the head this cycle
//   c_flush        redirect: drop queued and in-flight words
//   c_target       redirect PC (bits [1:0] ignored)
//   o_count        FIFO occupancy, 0..DEPTH
// ---------------------------------------------------------------------------

// Simulation-only guard: a push into a full FIFO must never happen.
module fetch_queue_chk (
    input logic clk,
    input logic rst_n,
    input logic push,
    input logic full
);
    no_push_when_full_a : assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
endmodule

module fetch_queue #(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic                       o_mem_en,
    output logic [ADDR_W-3:0]          o_mem_addr,
    input  logic [31:0]                i_mem_data,
    output logic [31:0]                o_instr,
    output logic [ADDR_W-1:0]          o_pc,
    output logic                       o_valid,
    input  logic                       i_next,
    input  logic                       c_flush,
    input  logic [ADDR_W-1:0]          c_target,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [ADDR_W-1:0] req_pc_r;
    logic [ADDR_W-1:0] shadow_pc_r;
    logic              inflight_r;
    logic [ADDR_W-1:0] fifo_pc_r    [DEPTH];
    logic [31:0]       fifo_instr_r [DEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [PW-1:0]     rd_ptr_nxt_s;
    logic [CW-1:0]     count_r;
    logic [CW-1:0]     count_after_pop_s;
    logic [CW-1:0]     count_nxt_s;
    logic [ADDR_W-1:0] head_pc_r;
    logic [ADDR_W-1:0] head_pc_nxt_s;
    logic [31:0]       head_instr_r;
    logic [31:0]       head_instr_nxt_s;
    logic [CW:0]       credit_s;
    logic              fifo_empty_s;
    logic              fifo_full_s;
    logic              issue_s;
    logic              push_s;
    logic              pop_s;
`ifdef FETCH_QUEUE_BYPASS_EN
    logic              bypass_s;
`endif

    // Issue credit and push/pop qualification; flush overrides everything.
    always_comb begin
        fifo_empty_s = (count_r == {CW{1'b0}});
        fifo_full_s  = (count_r == CW'(DEPTH));
        // Credit counts the word in flight; a same-cycle pop is not credited,
        // so a returning word always finds a free slot.
        credit_s     = {1'b0, count_r} + (CW+1)'(inflight_r);
        issue_s      = rst_n && !c_flush && (credit_s < (CW+1)'(DEPTH));
        pop_s        = !fifo_empty_s && i_next && !c_flush;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass_s     = fifo_empty_s && inflight_r && !c_flush;
        // A bypassed word taken by decode in the same cycle is never stored.
        push_s       = inflight_r && !c_flush && !(bypass_s && i_next);
`else
        push_s       = inflight_r && !c_flush;
`endif
    end

    // Next occupancy, read pointer and head contents.
    always_comb begin
        count_after_pop_s = count_r - CW'(pop_s);
        count_nxt_s       = count_after_pop_s + CW'(push_s);
        rd_ptr_nxt_s      = rd_ptr_r + PW'(pop_s);
        head_pc_nxt_s     = head_pc_r;
        head_instr_nxt_s  = head_instr_r;
        if (count_after_pop_s != {CW{1'b0}}) begin
            // Surviving entry at the new read pointer becomes the head.
            head_pc_nxt_s    = fifo_pc_r[rd_ptr_nxt_s];
            head_instr_nxt_s = fifo_instr_r[rd_ptr_nxt_s];
        end else if (push_s) begin
            // FIFO drains to empty this cycle: the word being written is the head.
            head_pc_nxt_s    = shadow_pc_r;
            head_instr_nxt_s = i_mem_data;
        end else begin
            head_pc_nxt_s    = head_pc_r;
            head_instr_nxt_s = head_instr_r;
        end
    end

    // FIFO control, head registers and fetch request state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r     <= {PW{1'b0}};
            rd_ptr_r     <= {PW{1'b0}};
            count_r      <= {CW{1'b0}};
            head_pc_r    <= {ADDR_W{1'b0}};
            head_instr_r <= 32'h0000_0000;
            req_pc_r     <= RESET_PC;
            shadow_pc_r  <= {ADDR_W{1'b0}};
            inflight_r   <= 1'b0;
        end else if (c_flush) begin
            wr_ptr_r     <= {PW{1'b0}};
            rd_ptr_r     <= {PW{1'b0}};
            count_r      <= {CW{1'b0}};
            req_pc_r     <= c_target & {{(ADDR_W-2){1'b1}}, 2'b00};
            inflight_r   <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1'b1);
            end
            rd_ptr_r     <= rd_ptr_nxt_s;
            count_r      <= count_nxt_s;
            head_pc_r    <= head_pc_nxt_s;
            head_instr_r <= head_instr_nxt_s;
            if (issue_s) begin
                req_pc_r    <= req_pc_r + ADDR_W'(3'd4);
                shadow_pc_r <= req_pc_r;
            end
            inflight_r   <= issue_s;
        end
    end

    // FIFO storage; contents are meaningless outside the valid window.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_pc_r[wr_ptr_r]    <= shadow_pc_r;
            fifo_instr_r[wr_ptr_r] <= i_mem_data;
        end
    end

    assign o_mem_en   = issue_s;
    assign o_mem_addr = req_pc_r[ADDR_W-1:2];
    assign o_count    = count_r;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign o_valid = (!fifo_empty_s || bypass_s) && !c_flush;
    assign o_instr = bypass_s ? i_mem_data  : head_instr_r;
    assign o_pc    = bypass_s ? shadow_pc_r : head_pc_r;
`else
    assign o_valid = !fifo_empty_s && !c_flush;
    assign o_instr = head_instr_r;
    assign o_pc    = head_pc_r;
`endif

    fetch_queue_chk u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .full  (fifo_full_s)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
// Directed bench for fetch_queue. Two instances: the main one (RESET_PC=0)
// is driven through stall, flush and reset scenarios; a second one with
// RESET_PC=FFFF_FFF8 streams freely to exercise PC wrap-around. BRAM word at
// word address a holds 0x1000+a. Expected PCs are queued whenever a reset
// or redirect is driven and popped as decode consumes words.
// ---------------------------------------------------------------------------
module tb_fetch_queue;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_en;
    logic [29:0] mem_addr;
    logic [31:0] mem_data = 32'h0000_0000;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        next;
    logic        flush;
    logic [31:0] target;
    logic [2:0]  count;

    logic        w_mem_en;
    logic [29:0] w_mem_addr;
    logic [31:0] w_mem_data = 32'h0000_0000;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic        w_valid;
    logic        w_next   = 1'b1;
    logic        w_flush  = 1'b0;
    logic [31:0] w_target = 32'h0000_0000;
    logic [2:0]  w_count;

    int passed = 0;
    int total  = 0;
    int w_delivered = 0;
    logic [31:0] exp_q[$];
    logic [31:0] w_exp_q[$];

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(4), .ADDR_W(32), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst_n(rst_n), .o_mem_en(mem_en), .o_mem_addr(mem_addr),
        .i_mem_data(mem_data), .o_instr(instr), .o_pc(pc), .o_valid(valid),
        .i_next(next), .c_flush(flush), .c_target(target), .o_count(count)
    );

    fetch_queue #(.DEPTH(4), .ADDR_W(32), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst_n(rst_n), .o_mem_en(w_mem_en), .o_mem_addr(w_mem_addr),
        .i_mem_data(w_mem_data), .o_instr(w_instr), .o_pc(w_pc), .o_valid(w_valid),
        .i_next(w_next), .c_flush(w_flush), .c_target(w_target), .o_count(w_count)
    );

    // Synchronous BRAM models, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) mem_data <= 32'h0000_1000 + {2'b00, mem_addr};
        if (w_mem_en) w_mem_data <= 32'h0000_1000 + {2'b00, w_mem_addr};
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] instr_of(input logic [31:0] p);
        return 32'h0000_1000 + {2'b00, p[31:2]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_main(input logic [31:0] start);
        exp_q.delete();
        for (int k = 0; k < 256; k++) exp_q.push_back(start + 32'(k * 4));
    endtask

    task automatic load_wrap();
        w_exp_q.delete();
        w_delivered = 0;
        for (int k = 0; k < 256; k++) w_exp_q.push_back(32'hFFFF_FFF8 + 32'(k * 4));
    endtask

    // One clock: score consumed words at the falling edge, return 1 after the rising edge.
    task automatic tick();
        logic [31:0] e;
        @(negedge clk);
        if (valid && next && !flush) begin
            chk("sb_main_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_main_pc", pc, e);
                chk("sb_main_instr", instr, instr_of(e));
            end
        end
        if (w_valid) begin
            chk("sb_wrap_nonempty", 64'(w_exp_q.size() != 0), 64'd1);
            if (w_exp_q.size() != 0) begin
                e = w_exp_q.pop_front();
                w_delivered++;
                chk("sb_wrap_pc", w_pc, e);
                chk("sb_wrap_instr", w_instr, instr_of(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    // After a flush edge or reset release: invalid until the latency elapses, then head = pexp.
    task automatic expect_first(input string tag, input logic [31:0] pexp);
        for (int i = 0; i < LAT - 2; i++) begin
            tick();
            chk({tag, "_gap"}, valid, 1'b0);
        end
        tick();
        chk({tag, "_valid"}, valid, 1'b1);
        chk({tag, "_pc"}, pc, pexp);
    endtask

    task automatic wait_count(input string tag, input logic [2:0] c, input logic need_idle);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (count == c && (!need_idle || !mem_en)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk(tag, ok, 1'b1);
    endtask

    initial begin
        rst_n  = 1'b0;
        next   = 1'b0;
        flush  = 1'b0;
        target = 32'h0000_0000;
        @(posedge clk);
        #1;
        chk("rst_valid", valid, 1'b0);
        chk("rst_count", count, 3'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_mem_en", mem_en, 1'b0);
        tick();
        tick();

        // Streaming from reset with decode always ready.
        rst_n = 1'b1;
        next  = 1'b1;
        load_main(32'h0000_0000);
        load_wrap();
        expect_first("rst_first", 32'h0000_0000);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("thru_valid", valid, 1'b1);
        end

        // Decode stalls: queue fills to DEPTH, fetch stops, head holds.
        next = 1'b0;
        repeat (20) tick();
        chk("stall_count", count, 3'd4);
        chk("stall_mem_en", mem_en, 1'b0);
        chk("stall_valid", valid, 1'b1);
        chk("stall_pc", pc, exp_q[0]);
        chk("stall_instr", instr, instr_of(exp_q[0]));
        next = 1'b1;
        repeat (12) tick();

        // Flush with three queued entries and one word in flight.
        next = 1'b0;
        wait_count("pre_flush_state", 3'd3, 1'b1);
        next   = 1'b1;
        flush  = 1'b1;
        target = 32'h0000_0040;
        #1;
        chk("flush_valid", valid, 1'b0);
        chk("flush_mem_en", mem_en, 1'b0);
        load_main(32'h0000_0040);
        tick();
        flush = 1'b0;
        expect_first("flush40", 32'h0000_0040);
        repeat (6) tick();

        // Unaligned target is aligned down.
        flush  = 1'b1;
        target = 32'h0000_0083;
        load_main(32'h0000_0080);
        tick();
        flush = 1'b0;
        expect_first("flush83", 32'h0000_0080);
        repeat (4) tick();

        // Back-to-back flushes: last target wins.
        flush  = 1'b1;
        target = 32'h0000_0080;
        load_main(32'h0000_0200);
        tick();
        target = 32'h0000_0200;
        tick();
        flush = 1'b0;
        expect_first("b2b", 32'h0000_0200);
        repeat (4) tick();

        // Asynchronous reset mid-stream with two entries queued.
        next = 1'b0;
        wait_count("pre_reset_state", 3'd2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", valid, 1'b0);
        chk("arst_count", count, 3'd0);
        chk("arst_mem_en", mem_en, 1'b0);
        chk("arst_pc", pc, 32'h0);
        chk("arst_instr", instr, 32'h0);
        chk("arst_wrap_valid", w_valid, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        next  = 1'b1;
        load_main(32'h0000_0000);
        load_wrap();
        expect_first("rst_resume", 32'h0000_0000);
        repeat (8) tick();
        chk("wrap_delivered", 64'(w_delivered >= 4), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
